// File: rtl/img_pkg.sv
// Shared constants for the image-processing datapath: default pixel width,
// the 3x3 window size and the rank positions for erode/denoise/dilate.
package img_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int WIN_3X3    = 9;
  localparam int RANK_MIN   = 0;

  function automatic int rank_med(input int win);
    return (win - 1) / 2;
  endfunction

  function automatic int rank_max(input int win);
    return win - 1;
  endfunction
endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange of two unsigned pixels. Equal inputs pass
// straight through, so the network never swaps equal values.
module cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);
  always_comb begin
    lo = a;
    hi = b;
    if (a > b) begin
      lo = b;
      hi = a;
    end
  end
endmodule

// File: rtl/rank_order_filter.sv
// Pipelined rank-order filter: registered odd-even transposition sort of a
// WIN-pixel window, then per-beat selection of the min/median/max (any rank).
module rank_order_filter
  import img_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIN    = WIN_3X3,
  parameter int RANK_W = $clog2(WIN)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIN*DATA_W-1:0]   i_pixel_data,
  input  logic                    i_pixel_data_valid,
  input  logic [RANK_W-1:0]       i_rank,
  output logic                    o_ready,
  output logic [DATA_W-1:0]       o_filter_data,
  output logic                    o_filter_data_valid,
  input  logic                    i_ready
);
  typedef logic [WIN-1:0][DATA_W-1:0] win_t;

  logic              adv;
  win_t              data_ps [WIN+1];
  logic [RANK_W-1:0] rank_ps [WIN+1];
  logic [WIN:0]      vld_ps;
  win_t              nxt_ps  [WIN];
  logic [DATA_W-1:0] data_sel_p;
  logic              vld_sel_p;

  // Ranks beyond the window (non power-of-two WIN) saturate to the maximum.
  function automatic logic [RANK_W-1:0] clamp_rank(input logic [RANK_W-1:0] r);
    if (r > RANK_W'(WIN - 1)) return RANK_W'(WIN - 1);
    return r;
  endfunction

  assign adv     = ~o_filter_data_valid | i_ready;
  assign o_ready = adv;

  // Stages 1..WIN: odd stages pair (0,1),(2,3)..; even stages pair (1,2),(3,4)..
  for (genvar s = 1; s <= WIN; s++) begin : g_stage
    localparam int P = (s % 2 == 1) ? 0 : 1;
    for (genvar k = 0; k < WIN; k++) begin : g_lane
      localparam bit IS_LO = (k >= P) && ((k - P) % 2 == 0) && (k + 1 < WIN);
      localparam bit IS_HI = (k >= P + 1) && ((k - 1 - P) % 2 == 0);
      if (IS_LO) begin : g_cs
        cmp_swap #(.DATA_W(DATA_W)) u_cs (
          .a  (data_ps[s-1][k]),
          .b  (data_ps[s-1][k+1]),
          .lo (nxt_ps[s-1][k]),
          .hi (nxt_ps[s-1][k+1])
        );
      end else if (!IS_HI) begin : g_pass
        assign nxt_ps[s-1][k] = data_ps[s-1][k];
      end
    end
  end

  // Data path: stage 0 capture, WIN sort stages, rank-select stage
  always_ff @(posedge i_clk) begin
    if (adv) begin
      data_ps[0] <= i_pixel_data;
      rank_ps[0] <= i_rank;
      for (int s = 1; s <= WIN; s++) begin
        data_ps[s] <= nxt_ps[s-1];
        rank_ps[s] <= rank_ps[s-1];
      end
      data_sel_p <= data_ps[WIN][clamp_rank(rank_ps[WIN])];
    end
  end

  // Control path and output register; the output pixel only updates on valid beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_ps              <= '0;
      vld_sel_p           <= 1'b0;
      o_filter_data_valid <= 1'b0;
      o_filter_data       <= '0;
    end else if (adv) begin
      vld_ps              <= {vld_ps[WIN-1:0], i_pixel_data_valid};
      vld_sel_p           <= vld_ps[WIN];
      o_filter_data_valid <= vld_sel_p;
      if (vld_sel_p) o_filter_data <= data_sel_p;
    end
  end
endmodule

// File: tb/tb_rank_order_filter.sv
// Random and directed checks of rank_order_filter (3x3/8-bit and 25/10-bit)
// against a sorted-queue reference model with an in-order scoreboard.
module tb_rank_order_filter;
  import img_pkg::*;

  localparam int DW_A = 8,  WIN_A = 9,  RW_A = 4;
  localparam int DW_B = 10, WIN_B = 25, RW_B = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIN_A*DW_A-1:0] i_data_a;
  logic                  i_valid_a, i_ready_a, o_ready_a, o_valid_a;
  logic [RW_A-1:0]       i_rank_a;
  logic [DW_A-1:0]       o_data_a;

  logic [WIN_B*DW_B-1:0] i_data_b;
  logic                  i_valid_b, i_ready_b, o_ready_b, o_valid_b;
  logic [RW_B-1:0]       i_rank_b;
  logic [DW_B-1:0]       o_data_b;

  rank_order_filter #(.DATA_W(DW_A), .WIN(WIN_A), .RANK_W(RW_A)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(i_data_a), .i_pixel_data_valid(i_valid_a),
    .i_rank(i_rank_a), .o_ready(o_ready_a), .o_filter_data(o_data_a),
    .o_filter_data_valid(o_valid_a), .i_ready(i_ready_a)
  );

  rank_order_filter #(.DATA_W(DW_B), .WIN(WIN_B), .RANK_W(RW_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(i_data_b), .i_pixel_data_valid(i_valid_b),
    .i_rank(i_rank_b), .o_ready(o_ready_b), .o_filter_data(o_data_b),
    .o_filter_data_valid(o_valid_b), .i_ready(i_ready_b)
  );

  typedef struct { int val; int cap; } exp_t;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   pix_a [WIN_A];
  int   pix_b [WIN_B];
  bit   mon_on = 1'b0;
  bit   lat_a  = 1'b1;
  logic [DW_A-1:0] last_a = '0;
  logic [DW_B-1:0] last_b = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: sort the window ascending, pick the clamped rank.
  function automatic int ref_rank(input int w[25], input int n, input int r);
    int q[$];
    for (int i = 0; i < n; i++) q.push_back(w[i]);
    q.sort();
    return q[(r > n - 1) ? n - 1 : r];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int   w[25];
    exp_t e;
    if (mon_on) begin
      chk("ready_a", o_ready_a, !o_valid_a || i_ready_a);
      if (o_valid_a) begin
        if (i_ready_a) begin
          if (qa.size() == 0) chk("extra_out_a", o_valid_a, 0);
          else begin
            e = qa.pop_front();
            chk("data_a", o_data_a, e.val);
            if (lat_a) chk("lat_a", cyc - e.cap, WIN_A + 2);
          end
        end
        last_a = o_data_a;
      end else chk("hold_a", o_data_a, last_a);
      if (rst) begin
        qa.delete();
        last_a = '0;
      end else if (i_valid_a && o_ready_a) begin
        for (int k = 0; k < 25; k++) w[k] = (k < WIN_A) ? int'(i_data_a[k*DW_A +: DW_A]) : 0;
        e.val = ref_rank(w, WIN_A, int'(i_rank_a));
        e.cap = cyc + 1;
        qa.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int   w[25];
    exp_t e;
    if (mon_on) begin
      if (o_valid_b) begin
        if (qb.size() == 0) chk("extra_out_b", o_valid_b, 0);
        else begin
          e = qb.pop_front();
          chk("data_b", o_data_b, e.val);
          chk("lat_b", cyc - e.cap, WIN_B + 2);
        end
        last_b = o_data_b;
      end else chk("hold_b", o_data_b, last_b);
      if (rst) begin
        qb.delete();
        last_b = '0;
      end else if (i_valid_b && o_ready_b) begin
        for (int k = 0; k < 25; k++) w[k] = int'(i_data_b[k*DW_B +: DW_B]);
        e.val = ref_rank(w, WIN_B, int'(i_rank_b));
        e.cap = cyc + 1;
        qb.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int r);
    bit took = 1'b0;
    for (int k = 0; k < WIN_A; k++) i_data_a[k*DW_A +: DW_A] = DW_A'(pix_a[k]);
    i_rank_a  = RW_A'(r);
    i_valid_a = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (o_ready_a) begin
        took = 1'b1;
        break;
      end
    end
    if (!took) chk("send_timeout_a", o_ready_a, 1);
    @(posedge clk);
    #1;
    i_valid_a = 1'b0;
  endtask

  task automatic send_b(input int r);
    bit took = 1'b0;
    for (int k = 0; k < WIN_B; k++) i_data_b[k*DW_B +: DW_B] = DW_B'(pix_b[k]);
    i_rank_b  = RW_B'(r);
    i_valid_b = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (o_ready_b) begin
        took = 1'b1;
        break;
      end
    end
    if (!took) chk("send_timeout_b", o_ready_b, 1);
    @(posedge clk);
    #1;
    i_valid_b = 1'b0;
  endtask

  task automatic rand_a(input int hi);
    for (int k = 0; k < WIN_A; k++) pix_a[k] = $urandom_range(0, hi);
  endtask

  initial begin
    i_data_a = '0; i_valid_a = 1'b0; i_rank_a = '0; i_ready_a = 1'b1;
    i_data_b = '0; i_valid_b = 1'b0; i_rank_b = '0; i_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_vld_a", o_valid_a, 0);
    chk("rst_data_a", o_data_a, 0);
    chk("rst_ready_a", o_ready_a, 1);
    chk("rst_vld_b", o_valid_b, 0);
    chk("rst_data_b", o_data_b, 0);
    mon_on = 1'b1;

    pix_a = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    send_a(rank_med(WIN_A));
    idle(15);
    send_a(RANK_MIN);
    send_a(rank_max(WIN_A));
    send_a(rank_med(WIN_A));
    idle(15);

    pix_a = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    send_a(4);
    pix_a = '{0, 255, 0, 255, 0, 255, 0, 255, 0};
    send_a(4);
    send_a(15);
    for (int i = 0; i < 8; i++) begin
      rand_a(3);
      send_a($urandom_range(0, 15));
    end
    idle(15);

    lat_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rand_a(255);
          send_a($urandom_range(0, 15));
        end
      end
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (o_valid_a) break;
        end
        chk("first_out_a", o_valid_a, 1);
        repeat (5) @(posedge clk);
        #1;
        i_ready_a = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready_a", o_ready_a, 0);
        end
        @(posedge clk);
        #1;
        i_ready_a = 1'b1;
      end
    join
    for (int t = 0; t < 100 && qa.size() != 0; t++) @(negedge clk);
    idle(2);
    lat_a = 1'b1;

    for (int i = 0; i < 3; i++) begin
      rand_a(255);
      send_a($urandom_range(0, 8));
    end
    rand_a(255);
    for (int k = 0; k < WIN_A; k++) i_data_a[k*DW_A +: DW_A] = DW_A'(pix_a[k]);
    i_rank_a  = 4'd4;
    i_valid_a = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    i_valid_a = 1'b0;
    chk("midrst_vld_a", o_valid_a, 0);
    chk("midrst_data_a", o_data_a, 0);
    chk("midrst_ready_a", o_ready_a, 1);
    rand_a(255);
    send_a(4);
    idle(15);

    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < WIN_B; k++) pix_b[k] = $urandom_range(0, 1023);
      send_b($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) idle(1);
    end

    for (int t = 0; t < 200; t++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
